// File: rtl/multicycle_controller.sv
// Multi-cycle RISC-V control sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK
// with data-memory timeout, sticky error flags and activity counters.
module multicycle_controller #(
    parameter int INST_WIDTH  = 32,
    parameter int CNT_WIDTH   = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic [INST_WIDTH-1:0] instruction,
    input  logic                  alu_zero,
    input  logic                  mem_ready,
    output logic                  ir_load,
    output logic                  pc_w_en,
    output logic                  pc_branch_sel,
    output logic                  reg_w_en,
    output logic                  mem_r,
    output logic                  mem_w,
    output logic                  mem_to_reg,
    output logic                  alu_src,
    output logic [1:0]            alu_op,
    output logic [2:0]            state,
    output logic                  illegal,
    output logic                  mem_timeout_err,
    output logic [CNT_WIDTH-1:0]  cycle_count,
    output logic [CNT_WIDTH-1:0]  instret_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEM       = 3'd4,
        S_WRITEBACK = 3'd5,
        S_ERROR     = 3'd7
    } state_e;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [7:0] TMO   = 8'(MEM_TIMEOUT);

    state_e               state_q, state_d;
    logic                 illegal_q, illegal_d;
    logic                 err_q, err_d;
    logic [7:0]           tcnt_q, tcnt_d;
    logic [CNT_WIDTH-1:0] cycle_q, cycle_d;
    logic [CNT_WIDTH-1:0] instret_q, instret_d;

    logic [6:0] opcode;
    logic       is_r, is_i, is_ld, is_st, is_br, is_legal;
    logic       retire;
    logic       active;
    logic       unused_inst;

    assign opcode      = instruction[6:0];
    assign unused_inst = ^instruction[INST_WIDTH-1:7];
    assign is_r        = (opcode == OP_R);
    assign is_i        = (opcode == OP_I);
    assign is_ld       = (opcode == OP_LD);
    assign is_st       = (opcode == OP_ST);
    assign is_br       = (opcode == OP_BR);
    assign is_legal    = is_r | is_i | is_ld | is_st | is_br;

    // Next-state, sticky flags, timeout count and per-cycle strobes
    always_comb begin
        state_d       = state_q;
        illegal_d     = illegal_q;
        err_d         = err_q;
        tcnt_d        = 8'd0;
        retire        = 1'b0;
        ir_load       = 1'b0;
        pc_w_en       = 1'b0;
        pc_branch_sel = 1'b0;
        reg_w_en      = 1'b0;
        mem_r         = 1'b0;
        mem_w         = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                ir_load = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_legal) begin
                    state_d = S_EXECUTE;
                end else begin
                    illegal_d = 1'b1;
                    pc_w_en   = 1'b1;
                    state_d   = run ? S_FETCH : S_IDLE;
                end
            end
            S_EXECUTE: begin
                if (is_br) begin
                    pc_w_en       = 1'b1;
                    pc_branch_sel = alu_zero;
                    retire        = 1'b1;
                end else if (is_ld || is_st) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEM: begin
                mem_r = is_ld;
                mem_w = is_st;
                if (mem_ready) begin
                    if (is_st) begin
                        pc_w_en = 1'b1;
                        retire  = 1'b1;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end else if (tcnt_q + 8'd1 >= TMO) begin
                    state_d = S_ERROR;
                    err_d   = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            S_WRITEBACK: begin
                reg_w_en = 1'b1;
                pc_w_en  = 1'b1;
                retire   = 1'b1;
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (retire) state_d = run ? S_FETCH : S_IDLE;
    end

    // Datapath selects decoded from the opcode while an instruction is live
    always_comb begin
        alu_op     = 2'b00;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        if (state_q inside {S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK}) begin
            mem_to_reg = is_ld;
            unique case (1'b1)
                is_ld, is_st: begin
                    alu_op  = 2'b00;
                    alu_src = 1'b1;
                end
                is_br: alu_op = 2'b01;
                is_r:  alu_op = 2'b10;
                is_i: begin
                    alu_op  = 2'b11;
                    alu_src = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Activity and retirement counters, frozen in IDLE and ERROR
    always_comb begin
        active    = (state_q != S_IDLE) && (state_q != S_ERROR);
        cycle_d   = active ? cycle_q + CNT_WIDTH'(1) : cycle_q;
        instret_d = retire ? instret_q + CNT_WIDTH'(1) : instret_q;
    end

    // State, flags and counters register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
            err_q     <= 1'b0;
            tcnt_q    <= 8'd0;
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            err_q     <= err_d;
            tcnt_q    <= tcnt_d;
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    assign state           = state_q;
    assign illegal         = illegal_q;
    assign mem_timeout_err = err_q;
    assign cycle_count     = cycle_q;
    assign instret_count   = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: instruction-level model drives expected
// per-cycle outputs; a negedge process compares them against the DUT.
module tb_multicycle_controller;

    localparam int TMO = 4;

    logic        clk;
    logic        rst;
    logic        run;
    logic [31:0] instruction;
    logic        alu_zero;
    logic        mem_ready;
    logic        ir_load, pc_w_en, pc_branch_sel, reg_w_en;
    logic        mem_r, mem_w, mem_to_reg, alu_src;
    logic [1:0]  alu_op;
    logic [2:0]  state;
    logic        illegal, mem_timeout_err;
    logic [31:0] cycle_count, instret_count;

    multicycle_controller #(
        .INST_WIDTH (32),
        .CNT_WIDTH  (32),
        .MEM_TIMEOUT(TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .run            (run),
        .instruction    (instruction),
        .alu_zero       (alu_zero),
        .mem_ready      (mem_ready),
        .ir_load        (ir_load),
        .pc_w_en        (pc_w_en),
        .pc_branch_sel  (pc_branch_sel),
        .reg_w_en       (reg_w_en),
        .mem_r          (mem_r),
        .mem_w          (mem_w),
        .mem_to_reg     (mem_to_reg),
        .alu_src        (alu_src),
        .alu_op         (alu_op),
        .state          (state),
        .illegal        (illegal),
        .mem_timeout_err(mem_timeout_err),
        .cycle_count    (cycle_count),
        .instret_count  (instret_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic        ir, pcw, pcb, rw, mr, mw, m2r, asrc;
        logic [1:0]  aop;
        logic        ill, terr;
        logic [31:0] cyc, ret;
    } obs_t;

    localparam logic [31:0] ADD  = 32'h002081B3;
    localparam logic [31:0] LW   = 32'h0000A183;
    localparam logic [31:0] BEQ  = 32'h00208463;
    localparam logic [31:0] SW   = 32'h0020A023;
    localparam logic [31:0] ADDI = 32'h00108093;
    localparam logic [31:0] BAD  = 32'h0000007F;

    int          n_checks = 0;
    int          n_err    = 0;
    obs_t        exp_cur;
    string       exp_tag;
    logic        exp_valid = 1'b0;

    logic [31:0] m_cyc, m_ret;
    logic        m_ill, m_err;

    function automatic obs_t sample();
        obs_t o;
        o.st   = state;
        o.ir   = ir_load;
        o.pcw  = pc_w_en;
        o.pcb  = pc_branch_sel;
        o.rw   = reg_w_en;
        o.mr   = mem_r;
        o.mw   = mem_w;
        o.m2r  = mem_to_reg;
        o.asrc = alu_src;
        o.aop  = alu_op;
        o.ill  = illegal;
        o.terr = mem_timeout_err;
        o.cyc  = cycle_count;
        o.ret  = instret_count;
        return o;
    endfunction

    // Per-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        obs_t a;
        if (exp_valid) begin
            a = sample();
            n_checks++;
            if (a !== exp_cur) begin
                n_err++;
                $display("FAIL %s: got %h want %h", exp_tag, a, exp_cur);
            end
        end
    end

    task automatic chk(input string name, input logic [79:0] got,
                       input logic [79:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic model_reset();
        m_cyc = 0;
        m_ret = 0;
        m_ill = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic tick(input string tag, input logic [2:0] st,
                        input logic [31:0] ins, input logic rdy,
                        input logic rn, input logic az,
                        input logic ir, pcw, pcb, rw, mr, mw,
                        input logic m2r, asrc, input logic [1:0] aop);
        @(posedge clk);
        #1;
        instruction = ins;
        mem_ready   = rdy;
        run         = rn;
        alu_zero    = az;
        exp_cur.st   = st;
        exp_cur.ir   = ir;
        exp_cur.pcw  = pcw;
        exp_cur.pcb  = pcb;
        exp_cur.rw   = rw;
        exp_cur.mr   = mr;
        exp_cur.mw   = mw;
        exp_cur.m2r  = m2r;
        exp_cur.asrc = asrc;
        exp_cur.aop  = aop;
        if (st == 3'd0 || st == 3'd1 || st == 3'd7) begin
            exp_cur.m2r  = 1'b0;
            exp_cur.asrc = 1'b0;
            exp_cur.aop  = 2'b00;
        end
        exp_cur.ill  = m_ill;
        exp_cur.terr = m_err;
        exp_cur.cyc  = m_cyc;
        exp_cur.ret  = m_ret;
        exp_tag      = tag;
        exp_valid    = 1'b1;
        if (st != 3'd0 && st != 3'd7) m_cyc++;
    endtask

    task automatic idle(input string tag, input logic rn);
        tick(tag, 3'd0, instruction, 1'b0, rn, 1'b0,
             0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    endtask

    // One whole instruction from FETCH to retirement (or timeout)
    task automatic exec(input string tag, input logic [31:0] ins,
                        input int waits, input logic az,
                        input logic run_mid, input logic run_after);
        logic [1:0] aop;
        logic       asrc, m2r;
        int         kind;
        aop  = 2'b00;
        asrc = 1'b0;
        m2r  = 1'b0;
        case (ins[6:0])
            7'b0110011: begin kind = 0; aop = 2'b10; end
            7'b0010011: begin kind = 1; aop = 2'b11; asrc = 1'b1; end
            7'b0000011: begin kind = 2; asrc = 1'b1; m2r = 1'b1; end
            7'b0100011: begin kind = 3; asrc = 1'b1; end
            7'b1100011: begin kind = 4; aop = 2'b01; end
            default:    kind = 5;
        endcase
        tick({tag, "/F"}, 3'd1, ins, 1'b0, 1'b1, az,
             1, 0, 0, 0, 0, 0, m2r, asrc, aop);
        if (kind == 5) begin
            tick({tag, "/D"}, 3'd2, ins, 1'b0, run_after, az,
                 0, 1, 0, 0, 0, 0, 0, 0, 2'b00);
            m_ill = 1'b1;
            return;
        end
        tick({tag, "/D"}, 3'd2, ins, 1'b0, 1'b1, az,
             0, 0, 0, 0, 0, 0, m2r, asrc, aop);
        if (kind == 4) begin
            tick({tag, "/E"}, 3'd3, ins, 1'b0, run_after, az,
                 0, 1, az, 0, 0, 0, m2r, asrc, aop);
            m_ret++;
            return;
        end
        tick({tag, "/E"}, 3'd3, ins, 1'b0, run_mid, az,
             0, 0, 0, 0, 0, 0, m2r, asrc, aop);
        if (kind == 2 || kind == 3) begin
            for (int i = 0; i < TMO; i++) begin
                logic rdy;
                rdy = (i == waits);
                if (rdy && kind == 3) begin
                    tick({tag, "/M"}, 3'd4, ins, 1'b1, run_after, az,
                         0, 1, 0, 0, 0, 1, m2r, asrc, aop);
                    m_ret++;
                    return;
                end
                tick({tag, "/M"}, 3'd4, ins, rdy, run_mid, az,
                     0, 0, 0, 0, kind == 2, kind == 3, m2r, asrc, aop);
                if (rdy) break;
                if (i == TMO - 1) begin
                    m_err = 1'b1;
                    return;
                end
            end
        end
        tick({tag, "/W"}, 3'd5, ins, 1'b0, run_after, az,
             0, 1, 0, 1, 0, 0, m2r, asrc, aop);
        m_ret++;
    endtask

    initial begin
        rst         = 1'b0;
        run         = 1'b0;
        instruction = 32'h0;
        alu_zero    = 1'b0;
        mem_ready   = 1'b0;
        model_reset();
        #2;
        chk("reset_all", 80'(sample()), 80'h0);
        @(negedge clk);
        rst = 1'b1;

        idle("start", 1'b1);
        exec("add", ADD, 0, 1'b0, 1'b1, 1'b1);
        exec("lw_w2", LW, 2, 1'b0, 1'b1, 1'b0);
        idle("idle_a", 1'b1);
        chk("cyc_after_lw", 80'(cycle_count), 80'd11);
        chk("ret_after_lw", 80'(instret_count), 80'd2);
        exec("beq_t", BEQ, 0, 1'b1, 1'b1, 1'b1);
        exec("beq_n", BEQ, 0, 1'b0, 1'b1, 1'b1);
        exec("bad", BAD, 0, 1'b0, 1'b1, 1'b0);
        idle("idle_b", 1'b1);
        chk("ill_set", 80'(illegal), 80'd1);
        chk("cyc_after_bad", 80'(cycle_count), 80'd19);
        chk("ret_after_bad", 80'(instret_count), 80'd4);
        exec("add2", ADD, 0, 1'b0, 1'b1, 1'b1);
        exec("sw_w0", SW, 0, 1'b0, 1'b1, 1'b1);
        exec("lw_w3", LW, 3, 1'b0, 1'b1, 1'b1);
        exec("addi", ADDI, 0, 1'b1, 1'b1, 1'b1);
        exec("add_drop", ADD, 0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) idle("idle_hold", 1'b0);
        chk("cyc_frozen", 80'(cycle_count), 80'd43);
        chk("ret_final", 80'(instret_count), 80'd9);
        chk("ill_sticky", 80'(illegal), 80'd1);

        idle("idle_c", 1'b1);
        tick("rm/F", 3'd1, LW, 1'b0, 1'b1, 1'b0,
             1, 0, 0, 0, 0, 0, 1, 1, 2'b00);
        tick("rm/D", 3'd2, LW, 1'b0, 1'b1, 1'b0,
             0, 0, 0, 0, 0, 0, 1, 1, 2'b00);
        tick("rm/E", 3'd3, LW, 1'b0, 1'b1, 1'b0,
             0, 0, 0, 0, 0, 0, 1, 1, 2'b00);
        tick("rm/M", 3'd4, LW, 1'b0, 1'b1, 1'b0,
             0, 0, 0, 0, 1, 0, 1, 1, 2'b00);
        chk("rm_mem_r_hi", 80'(mem_r), 80'd1);
        exp_valid = 1'b0;
        run       = 1'b0;
        rst       = 1'b0;
        #1;
        chk("rm_mem_r_lo", 80'(mem_r), 80'd0);
        chk("rm_all_zero", 80'(sample()), 80'h0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();

        idle("idle_d", 1'b1);
        exec("sw_tmo", SW, 99, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++)
            tick("err", 3'd7, SW, 1'b1, 1'b1, 1'b0,
                 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        chk("err_state", 80'(state), 80'd7);
        chk("err_flag", 80'(mem_timeout_err), 80'd1);
        chk("err_cyc", 80'(cycle_count), 80'd7);
        exp_valid = 1'b0;
        run       = 1'b0;
        rst       = 1'b0;
        #1;
        chk("err_reset", 80'(sample()), 80'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
